ripple_nibble_seq: RTL and testbench

//   Sequences one external 4-bit combinational ripple adder to add two WIDTH-bit operands.

---
 rtl/ripple_nibble_seq_if.sv | 38 +++
 rtl/ripple_nibble_seq.sv | 138 +++++++++++++
 tb/tb_ripple_nibble_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ripple_nibble_seq_if.sv
// ripple_nibble_seq_if
//   Bundles the requester handshake and the shared 4-bit adder connection of
//   ripple_nibble_seq.
//   Requester side: start, a, b, cin -> sequencer; busy, done, sum, cout <- sequencer.
//   Adder side:     add_a, add_b, add_cin -> adder; add_s, add_cout <- adder
//                   (the adder is combinational; its result returns in the same cycle).
//   Modports:
//     slave  - the sequencer itself
//     master - the environment, i.e. the requester together with the adder
interface ripple_nibble_seq_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;

  modport slave (
    input  start, a, b, cin, add_s, add_cout,
    output busy, done, sum, cout, add_a, add_b, add_cin
  );

  modport master (
    output start, a, b, cin, add_s, add_cout,
    input  busy, done, sum, cout, add_a, add_b, add_cin
  );

endinterface

// File: rtl/ripple_nibble_seq.sv
// ripple_nibble_seq
//   Adds two WIDTH-bit operands with one shared external 4-bit ripple adder.
//   One nibble is added per cycle, LSB nibble first.  The carry between
//   nibbles is held in a flop.  The result is {cout,sum} = a + b + cin.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset; discards any operation in flight
//     bus  - ripple_nibble_seq_if.slave:
//            start/a/b/cin in; busy/done/sum/cout out (requester side)
//            add_a/add_b/add_cin out; add_s/add_cout in (adder side)
//   Timing: start accepted at edge k -> NIB RUN cycles -> done high for one
//   cycle, immediately after edge k+NIB.  One operation per NIB+2 cycles.
module ripple_nibble_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  ripple_nibble_seq_if.slave  bus
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;

  // Nibble select as an explicit mux over all legal idx values, so no
  // part-select can ever reach past the operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  // Next state and adder drive.  Outside RUN the adder inputs are held at
  // zero so the shared datapath stays quiet.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        add_a   = a_nib;
        add_b   = b_nib;
        add_cin = carry;
        if (idx == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          // Adder result arrives combinationally in this same cycle.
          for (int unsigned i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
              sum_r[4*i +: 4] <= bus.add_s;
            end
          end
          carry <= bus.add_cout;
          if (idx == LAST) begin
            cout_r <= bus.add_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.sum     = sum_r;
  assign bus.cout    = cout_r;
  assign bus.add_a   = add_a;
  assign bus.add_b   = add_b;
  assign bus.add_cin = add_cin;

endmodule

// File: tb/tb_ripple_nibble_seq.sv
// tb_ripple_nibble_seq
//   Directed bench for ripple_nibble_seq at WIDTH=16 and WIDTH=4.  Each
//   instance is paired with a behavioural 4-bit adder on its interface.
module tb_ripple_nibble_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ripple_nibble_seq_if #(.WIDTH(16)) b16 ();
  ripple_nibble_seq_if #(.WIDTH(4))  b4 ();

  assign {b16.add_cout, b16.add_s} = {1'b0, b16.add_a} + {1'b0, b16.add_b} + {4'b0, b16.add_cin};
  assign {b4.add_cout,  b4.add_s}  = {1'b0, b4.add_a}  + {1'b0, b4.add_b}  + {4'b0, b4.add_cin};

  ripple_nibble_seq #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  ripple_nibble_seq #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the accepting edge pass.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    b16.start = 1'b1;
    b16.a     = a;
    b16.b     = b;
    b16.cin   = cin;
    tick();
    b16.start = 1'b0;
  endtask

  // Edges waited after the accepting edge until done is seen (bounded).
  task automatic wait_done16(input string tag, output int n);
    n = 0;
    while (!b16.done && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(b16.done), 32'd1);
  endtask

  int n;
  int dones;
  int d1;
  int d2;
  int t;
  logic [3:0] ea [4];
  logic [3:0] eb [4];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    b16.start = 1'b0;
    b16.a     = 16'h1234;
    b16.b     = 16'hABCD;
    b16.cin   = 1'b1;
    b4.start  = 1'b0;
    b4.a      = 4'h0;
    b4.b      = 4'h0;
    b4.cin    = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state; operands present but no start, so adder stays idle.
    chk("rst_busy",    32'(b16.busy),    32'd0);
    chk("rst_done",    32'(b16.done),    32'd0);
    chk("rst_sum",     32'(b16.sum),     32'h0);
    chk("rst_cout",    32'(b16.cout),    32'd0);
    chk("idle_add_a",  32'(b16.add_a),   32'h0);
    chk("idle_add_b",  32'(b16.add_b),   32'h0);
    chk("idle_add_cin",32'(b16.add_cin), 32'd0);

    // 1: 0x0001 + 0xFFFF -> {1,0x0000}; done in cycle k+5.
    start16(16'h0001, 16'hFFFF, 1'b0);
    chk("t1_busy_run", 32'(b16.busy), 32'd1);
    wait_done16("t1_done_seen", n);
    chk("t1_latency", 32'(n + 1), 32'd5);
    chk("t1_sum",     32'(b16.sum),  32'h0000);
    chk("t1_cout",    32'(b16.cout), 32'd1);
    chk("t1_busy_done", 32'(b16.busy), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(b16.done), 32'd0);
    chk("t1_busy_idle",  32'(b16.busy), 32'd0);
    chk("t1_sum_hold",   32'(b16.sum),  32'h0000);

    // 2: 0x1234 + 0x4321 + 1 = 0x5556; adder sees nibbles LSB first.
    ea = '{4'h4, 4'h3, 4'h2, 4'h1};
    eb = '{4'h1, 4'h2, 4'h3, 4'h4};
    start16(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_add_a%0d", i), 32'(b16.add_a), 32'(ea[i]));
      chk($sformatf("t2_add_b%0d", i), 32'(b16.add_b), 32'(eb[i]));
      if (i == 0) chk("t2_add_cin0", 32'(b16.add_cin), 32'd1);
      tick();
    end
    chk("t2_done", 32'(b16.done), 32'd1);
    chk("t2_sum",  32'(b16.sum),  32'h5556);
    chk("t2_cout", 32'(b16.cout), 32'd0);
    tick();

    // 3: start pulsed with new operands throughout RUN and DONE is ignored.
    start16(16'h00FF, 16'h0F0F, 1'b0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      b16.start = 1'b1;
      b16.a     = 16'($urandom);
      b16.b     = 16'($urandom);
      b16.cin   = 1'b1;
      tick();
      if (b16.done) begin
        dones++;
        chk("t3_sum_at_done", 32'(b16.sum), 32'h100E);
      end
    end
    b16.start = 1'b0;
    repeat (6) begin
      tick();
      if (b16.done) dones++;
    end
    chk("t3_done_count", 32'(dones), 32'd1);
    chk("t3_sum",  32'(b16.sum),  32'h100E);
    chk("t3_cout", 32'(b16.cout), 32'd0);
    chk("t3_busy", 32'(b16.busy), 32'd0);

    // 4: reset in the second RUN cycle discards the operation.
    start16(16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", 32'(b16.busy), 32'd0);
    chk("t4_sum",  32'(b16.sum),  32'h0);
    chk("t4_cout", 32'(b16.cout), 32'd0);
    chk("t4_done", 32'(b16.done), 32'd0);
    dones = 0;
    repeat (6) begin
      tick();
      if (b16.done) dones++;
    end
    chk("t4_no_done", 32'(dones), 32'd0);
    start16(16'h0F00, 16'h0100, 1'b0);
    wait_done16("t4_next_done_seen", n);
    chk("t4_next_sum",  32'(b16.sum),  32'h1000);
    chk("t4_next_cout", 32'(b16.cout), 32'd0);
    tick();

    // 5: start held high -> accepts every 6 cycles.
    b16.start = 1'b1;
    b16.a     = 16'hFFFF;
    b16.b     = 16'h0001;
    b16.cin   = 1'b1;
    tick();
    b16.a   = 16'h7FFF;
    b16.b   = 16'h0001;
    b16.cin = 1'b0;
    t  = 0;
    d1 = -1;
    d2 = -1;
    while (t < 30 && d2 < 0) begin
      tick();
      t++;
      if (b16.done) begin
        if (d1 < 0) begin
          d1 = t;
          chk("t5_sum1",  32'(b16.sum),  32'h0001);
          chk("t5_cout1", 32'(b16.cout), 32'd1);
        end else begin
          d2 = t;
          chk("t5_sum2",  32'(b16.sum),  32'h8000);
          chk("t5_cout2", 32'(b16.cout), 32'd0);
          b16.start = 1'b0;
        end
      end
    end
    b16.start = 1'b0;
    chk("t5_done1_time", 32'(d1), 32'd4);
    chk("t5_spacing",    32'(d2 - d1), 32'd6);
    repeat (3) tick();
    chk("t5_busy_after", 32'(b16.busy), 32'd0);

    // 6: WIDTH=4, 0x1 + 0xF -> {1,0x0}; done in cycle k+2.
    b4.a   = 4'h1;
    b4.b   = 4'hF;
    b4.cin = 1'b0;
    #1;
    chk("w4_idle_add_a", 32'(b4.add_a), 32'h0);
    chk("w4_idle_add_b", 32'(b4.add_b), 32'h0);
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    chk("w4_run_add_a", 32'(b4.add_a), 32'h1);
    chk("w4_run_add_b", 32'(b4.add_b), 32'hF);
    n = 0;
    while (!b4.done && n < 20) begin
      tick();
      n++;
    end
    chk("w4_done_seen", 32'(b4.done), 32'd1);
    chk("w4_latency", 32'(n + 1), 32'd2);
    chk("w4_sum",  32'(b4.sum),  32'h0);
    chk("w4_cout", 32'(b4.cout), 32'd1);
    tick();
    chk("w4_after_add_a", 32'(b4.add_a), 32'h0);
    chk("w4_after_add_b", 32'(b4.add_b), 32'h0);
    chk("w4_after_busy",  32'(b4.busy),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
